fetch_arb: RTL and testbench
============================

// Module: fetch_arb
// PURPOSE
//  Shares the single line-fetch engine port (fetch_req/gnt/done, cmd, tag, addr) among N cache controllers
//  (write controller, read controller, ...). Round-robin arbitration; the grant stays locked until the engine's
//  fetch_done, so at most one fetch is in flight. Sits between the controllers and the fetch/writeback engine.
// PARAMETERS
//  addr_width  32  fetch address width
//  list_depth  4   cache lines; tag width = $clog2(list_depth)
//  n_req       2   number of requesters (>=2); owner index width = $clog2(n_req)
// PORTS
//  clk           in   1                  clock
//  rst           in   1                  synchronous reset, active-high
//  rq_req        in   n_req              per-requester fetch request; held until rq_gnt
//  rq_cmd        in   n_req x 2          per-requester fetch_cmd (00 writeback+fetch, 01 fetch)
//  rq_tag        in   n_req x tagw       per-requester line tag
//  rq_addr       in   n_req x addr_width per-requester line address
//  rq_gnt        out  n_req              one-hot; owner's handshake, same cycle as fetch_gnt
//  rq_done       out  n_req              one-hot 1-cycle pulse to owner on fetch_done
//  fetch_req     out  1                  to engine
//  fetch_cmd     out  2                  to engine
//  fetch_tag     out  tagw               to engine
//  fetch_addr    out  addr_width         to engine
//  fetch_gnt     in   1                  engine accepts request
//  fetch_done    in   1                  engine completes the in-flight fetch
//  arb_busy      out  1                  high in ISSUE or BUSY
//  arb_owner     out  $clog2(n_req)      current/last owner index
// BEHAVIOUR
//  States: IDLE, ISSUE, BUSY. Reset -> IDLE, rr_ptr=0, owner=0; all outputs 0.
//  IDLE: if |rq_req, owner <= first requester at/after rr_ptr (wrap n_req-1 -> 0); -> ISSUE. Else stay.
//  ISSUE: fetch_req = rq_req[owner]; cmd/tag/addr mux from owner (combinational, no payload register).
//   fetch_gnt & rq_req[owner]: rq_gnt[owner]=1 same cycle; -> BUSY.
//   rq_req[owner] drops before grant (protocol violation): fetch_req=0, -> IDLE, rr_ptr unchanged.
//  BUSY: fetch_req=0; fetch_done -> rq_done[owner]=1 one cycle, rr_ptr <= owner+1 (mod n_req), -> IDLE.
//  Latency: request to fetch_req = 1 cycle; done to next arbitration = 1 cycle (IDLE re-evaluates).
//  fetch_done in IDLE/ISSUE and fetch_gnt outside ISSUE are ignored (no state change, no pulses).
//  Simultaneous requests: rr_ptr decides; a requester granted last waits behind all others (no starvation).
//  Requesters that assert during ISSUE/BUSY wait; the request stays pending, nothing is lost.
//  rq_gnt/rq_done never assert for a non-owner; never more than one bit high.
//  rst mid-operation: abort to IDLE at next edge, no rq_done; the engine is reset by the same rst.
// CONFIGURATION
//  FETCH_ARB_WATCHDOG_EN defined: extra port wdog_err (out,1); 16-bit counter clears on entering BUSY,
//   increments each BUSY cycle, saturates; wdog_err=1 (sticky until rst) when it reaches 16'hFFFF.
//  Not defined: no counter, no wdog_err port; behaviour otherwise identical.
// STRUCTURE
//  cache_pkg: fetch_cmd_t (FETCH_WB_RD=2'b00, FETCH_RD=2'b01), fetch_arb_state_t enum.
//  Sub-module rr_picker (n_req): combinational req vector + ptr -> grant index + valid.
// TESTING
//  rq_req=2'b01, fetch_gnt in ISSUE, fetch_done 5 cycles later -> fetch_addr=rq_addr[0], rq_gnt=01, rq_done=01 once.
//  rq_req=2'b11 held after reset -> owner 0 first, then owner 1; rr_ptr=0 after second done.
//  Owner 0 drops rq_req in ISSUE with fetch_gnt=0 -> fetch_req falls, IDLE, no rq_gnt.
//  fetch_done pulse in IDLE -> no rq_done, state IDLE.
//  rst=1 in BUSY -> next cycle IDLE, arb_busy=0, rq_done never pulses.
//  FETCH_ARB_WATCHDOG_EN: BUSY 65535 cycles without done -> wdog_err=1, stays 1 after done.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types for the cache controller / fetch engine slice.
package cache_pkg;

  // Command presented to the line-fetch engine
  typedef enum logic [1:0] {
    FETCH_WB_RD = 2'b00,  // write back the victim line, then fetch
    FETCH_RD    = 2'b01   // fetch only
  } fetch_cmd_t;

  // Fetch arbiter state encoding
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_ISSUE = 2'b01,
    ARB_BUSY  = 2'b10
  } fetch_arb_state_t;

endpackage

// File: rtl/fetch_arb_rr_picker.sv
// Round-robin picker: first asserted request at or after ptr, wrapping at n_req-1.
module rr_picker #(
  parameter  int unsigned n_req = 2,
  localparam int unsigned OWN_W = $clog2(n_req)
) (
  input  logic [n_req-1:0] req,
  input  logic [OWN_W-1:0] ptr,
  output logic [OWN_W-1:0] grant_idx,
  output logic             grant_vld
);

  // Scan from ptr upwards, keep the first hit
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int unsigned i = 0; i < n_req; i++) begin
      int unsigned      cand;
      logic [OWN_W-1:0] cand_idx;
      cand = 32'(ptr) + i;
      if (cand >= n_req) cand = cand - n_req;
      cand_idx = OWN_W'(cand);
      if (!grant_vld && req[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fetch_arb.sv
// Round-robin arbiter sharing one line-fetch engine among n_req cache controllers.
// Grant is locked from arbitration until fetch_done; one fetch in flight at most.
// Optional: define FETCH_ARB_WATCHDOG_EN to add a BUSY-duration watchdog (wdog_err).
module fetch_arb
  import cache_pkg::*;
#(
  parameter  int unsigned addr_width = 32,
  parameter  int unsigned list_depth = 4,
  parameter  int unsigned n_req      = 2,
  localparam int unsigned TAG_W      = $clog2(list_depth),
  localparam int unsigned OWN_W      = $clog2(n_req)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [n_req-1:0]                      rq_req,
  input  logic [n_req-1:0][1:0]                 rq_cmd,
  input  logic [n_req-1:0][TAG_W-1:0]           rq_tag,
  input  logic [n_req-1:0][addr_width-1:0]      rq_addr,
  output logic [n_req-1:0]                      rq_gnt,
  output logic [n_req-1:0]                      rq_done,
  output logic                                  fetch_req,
  output logic [1:0]                            fetch_cmd,
  output logic [TAG_W-1:0]                      fetch_tag,
  output logic [addr_width-1:0]                 fetch_addr,
  input  logic                                  fetch_gnt,
  input  logic                                  fetch_done,
`ifdef FETCH_ARB_WATCHDOG_EN
  output logic                                  wdog_err,
`endif
  output logic                                  arb_busy,
  output logic [OWN_W-1:0]                      arb_owner
);

  localparam logic [1:0] ST_IDLE  = 2'(ARB_IDLE);
  localparam logic [1:0] ST_ISSUE = 2'(ARB_ISSUE);
  localparam logic [1:0] ST_BUSY  = 2'(ARB_BUSY);

  logic [1:0]       state_q, state_d;
  logic [OWN_W-1:0] owner_q, owner_d;
  logic [OWN_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [OWN_W-1:0] pick_idx;
  logic             pick_vld;

  rr_picker #(.n_req(n_req)) u_picker (
    .req       (rq_req),
    .ptr       (rr_ptr_q),
    .grant_idx (pick_idx),
    .grant_vld (pick_vld)
  );

  // State, owner and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next-state and engine/requester handshakes; payload muxed straight from the owner
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    fetch_req  = 1'b0;
    fetch_cmd  = '0;
    fetch_tag  = '0;
    fetch_addr = '0;
    rq_gnt     = '0;
    rq_done    = '0;
    arb_busy   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          owner_d = pick_idx;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        arb_busy   = 1'b1;
        fetch_req  = rq_req[owner_q];
        fetch_cmd  = rq_cmd[owner_q];
        fetch_tag  = rq_tag[owner_q];
        fetch_addr = rq_addr[owner_q];
        if (!rq_req[owner_q]) begin
          // requester withdrew before the engine accepted: re-arbitrate, pointer untouched
          state_d = ST_IDLE;
        end else if (fetch_gnt) begin
          rq_gnt[owner_q] = 1'b1;
          state_d         = ST_BUSY;
        end
      end
      ST_BUSY: begin
        arb_busy = 1'b1;
        if (fetch_done) begin
          rq_done[owner_q] = 1'b1;
          rr_ptr_d = (owner_q == OWN_W'(n_req - 1)) ? '0 : owner_q + 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // a reset cycle aborts the transaction; no handshake may escape
    if (rst) begin
      rq_gnt  = '0;
      rq_done = '0;
    end
  end

  assign arb_owner = owner_q;

`ifdef FETCH_ARB_WATCHDOG_EN
  logic [15:0] wdog_cnt_q;

  // Count BUSY cycles since the grant; flag a fetch that never completes
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_q <= '0;
      wdog_err   <= 1'b0;
    end else if (state_q == ST_ISSUE && state_d == ST_BUSY) begin
      wdog_cnt_q <= '0;
    end else if (state_q == ST_BUSY && wdog_cnt_q != 16'hFFFF) begin
      wdog_cnt_q <= wdog_cnt_q + 16'd1;
      if (wdog_cnt_q == 16'hFFFE) wdog_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_arb.sv
// Bench for fetch_arb: directed protocol cases, then randomized traffic checked
// by a scoreboard fed from a transaction-level arbitration model.
module tb_fetch_arb;
  import cache_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned LD = 4;
  localparam int unsigned NR = 2;
  localparam int unsigned TW = $clog2(LD);
  localparam int unsigned OW = $clog2(NR);
  localparam int RAND_CYCLES  = 3000;
  localparam int DRAIN_CYCLES = 40;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NR-1:0]          rq_req;
  logic [NR-1:0][1:0]     rq_cmd;
  logic [NR-1:0][TW-1:0]  rq_tag;
  logic [NR-1:0][AW-1:0]  rq_addr;
  logic [NR-1:0]          rq_gnt;
  logic [NR-1:0]          rq_done;
  logic                   fetch_req;
  logic [1:0]             fetch_cmd;
  logic [TW-1:0]          fetch_tag;
  logic [AW-1:0]          fetch_addr;
  logic                   fetch_gnt;
  logic                   fetch_done;
  logic                   arb_busy;
  logic [OW-1:0]          arb_owner;
`ifdef FETCH_ARB_WATCHDOG_EN
  logic                   wdog_err;
`endif

  always #5 clk = ~clk;

  fetch_arb #(.addr_width(AW), .list_depth(LD), .n_req(NR)) dut (
    .clk        (clk),
    .rst        (rst),
    .rq_req     (rq_req),
    .rq_cmd     (rq_cmd),
    .rq_tag     (rq_tag),
    .rq_addr    (rq_addr),
    .rq_gnt     (rq_gnt),
    .rq_done    (rq_done),
    .fetch_req  (fetch_req),
    .fetch_cmd  (fetch_cmd),
    .fetch_tag  (fetch_tag),
    .fetch_addr (fetch_addr),
    .fetch_gnt  (fetch_gnt),
    .fetch_done (fetch_done),
`ifdef FETCH_ARB_WATCHDOG_EN
    .wdog_err   (wdog_err),
`endif
    .arb_busy   (arb_busy),
    .arb_owner  (arb_owner)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got 0x%0h with nothing expected (t=%0t)", name, act, $time);
  endtask

  function automatic logic [NR-1:0] onehot(input int unsigned k);
    return NR'(1) << k;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    int unsigned   idx;
    logic [1:0]    cmd;
    logic [TW-1:0] tag;
    logic [AW-1:0] addr;
  } exp_gnt_t;

  exp_gnt_t    exp_gnt_q[$];
  int unsigned exp_done_q[$];
  bit          mon_en = 1'b0;

  // Monitor: sample just before each active edge, pop on every DUT handshake
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (mon_en) begin
        if (fetch_req && fetch_gnt) begin
          if (exp_gnt_q.size() == 0) begin
            fail_now("unexpected_handshake", 64'(rq_gnt));
          end else begin
            exp_gnt_t e;
            e = exp_gnt_q.pop_front();
            check("sb_gnt_onehot", 64'(rq_gnt), 64'(onehot(e.idx)));
            check("sb_owner", 64'(arb_owner), 64'(e.idx));
            check("sb_addr", 64'(fetch_addr), 64'(e.addr));
            check("sb_tag", 64'(fetch_tag), 64'(e.tag));
            check("sb_cmd", 64'(fetch_cmd), 64'(e.cmd));
          end
        end else begin
          check("sb_no_spurious_gnt", 64'(rq_gnt), 64'd0);
        end
        if (rq_done != '0) begin
          if (exp_done_q.size() == 0) begin
            fail_now("unexpected_done", 64'(rq_done));
          end else begin
            int unsigned k;
            k = exp_done_q.pop_front();
            check("sb_done_onehot", 64'(rq_done), 64'(onehot(k)));
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clr_inputs();
    rq_req     = '0;
    rq_cmd     = '0;
    rq_tag     = '0;
    rq_addr    = '0;
    fetch_gnt  = 1'b0;
    fetch_done = 1'b0;
  endtask

  // Leaves the bench at a falling edge with rst released
  task automatic do_reset();
    rst = 1'b1;
    clr_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int pulses;
    logic [NR-1:0] pend;
    logic [1:0]    p_cmd  [NR];
    logic [TW-1:0] p_tag  [NR];
    logic [AW-1:0] p_addr [NR];
    int            phase;   // 0 engine free, 1 waiting for engine grant, 2 fetch in flight
    int unsigned   m_own, m_ptr;
    bit            hs_last;

    // reset state
    do_reset();
    #3;
    check("rst_fetch_req", 64'(fetch_req), 64'd0);
    check("rst_rq_gnt", 64'(rq_gnt), 64'd0);
    check("rst_rq_done", 64'(rq_done), 64'd0);
    check("rst_busy", 64'(arb_busy), 64'd0);
    check("rst_owner", 64'(arb_owner), 64'd0);
    check("rst_addr", 64'(fetch_addr), 64'd0);

    // single requester, grant in ISSUE, done 5 cycles after grant
    @(negedge clk);
    rq_req     = 2'b01;
    rq_addr[0] = 32'hCAFE_0040;
    rq_cmd[0]  = 2'(FETCH_RD);
    rq_tag[0]  = 2'd2;
    rq_addr[1] = 32'h1111_0000;
    #3;
    check("t2_req_latency", 64'(fetch_req), 64'd0);
    @(negedge clk);
    #3;
    check("t2_fetch_req", 64'(fetch_req), 64'd1);
    check("t2_fetch_addr", 64'(fetch_addr), 64'hCAFE_0040);
    check("t2_fetch_tag", 64'(fetch_tag), 64'd2);
    check("t2_fetch_cmd", 64'(fetch_cmd), 64'd1);
    check("t2_no_gnt_yet", 64'(rq_gnt), 64'd0);
    check("t2_busy_issue", 64'(arb_busy), 64'd1);
    fetch_gnt = 1'b1;
    #1;
    check("t2_rq_gnt", 64'(rq_gnt), 64'b01);
    @(negedge clk);
    rq_req    = '0;
    fetch_gnt = 1'b0;
    pulses    = 0;
    for (int i = 0; i < 5; i++) begin
      fetch_done = (i == 4);
      #3;
      if (rq_done != '0) pulses++;
      if (i == 4) check("t2_rq_done", 64'(rq_done), 64'b01);
      else check("t2_busy_no_req", 64'(fetch_req), 64'd0);
      @(negedge clk);
    end
    fetch_done = 1'b0;
    #3;
    if (rq_done != '0) pulses++;
    check("t2_done_once", 64'(pulses), 64'd1);
    check("t2_idle_after", 64'(arb_busy), 64'd0);

    // both requesting from reset: owner 0, then 1, pointer back to 0
    do_reset();
    rq_req     = 2'b11;
    rq_addr[0] = 32'hA000_0000;
    rq_addr[1] = 32'hB000_0000;
    rq_tag[0]  = 2'd1;
    rq_tag[1]  = 2'd3;
    @(negedge clk);
    fetch_gnt = 1'b1;
    #3;
    check("t3_first_owner", 64'(arb_owner), 64'd0);
    check("t3_first_addr", 64'(fetch_addr), 64'hA000_0000);
    check("t3_first_gnt", 64'(rq_gnt), 64'b01);
    @(negedge clk);
    fetch_gnt  = 1'b0;
    rq_addr[0] = 32'hA000_1000;
    fetch_done = 1'b1;
    #3;
    check("t3_first_done", 64'(rq_done), 64'b01);
    @(negedge clk);
    fetch_done = 1'b0;
    #3;
    check("t3_idle_gap", 64'(arb_busy), 64'd0);
    @(negedge clk);
    fetch_gnt = 1'b1;
    #3;
    check("t3_second_owner", 64'(arb_owner), 64'd1);
    check("t3_second_addr", 64'(fetch_addr), 64'hB000_0000);
    check("t3_second_gnt", 64'(rq_gnt), 64'b10);
    @(negedge clk);
    fetch_gnt  = 1'b0;
    rq_req     = 2'b01;
    fetch_done = 1'b1;
    #3;
    check("t3_second_done", 64'(rq_done), 64'b10);
    @(negedge clk);
    fetch_done = 1'b0;
    rq_req     = 2'b11;
    @(negedge clk);
    #3;
    check("t3_ptr_wrap_owner", 64'(arb_owner), 64'd0);
    check("t3_ptr_wrap_addr", 64'(fetch_addr), 64'hA000_1000);

    // owner withdraws in ISSUE before the engine grants
    do_reset();
    rq_req     = 2'b01;
    rq_addr[0] = 32'h0000_0BAD;
    @(negedge clk);
    #3;
    check("t4_issue_req", 64'(fetch_req), 64'd1);
    rq_req = '0;
    #1;
    check("t4_req_falls", 64'(fetch_req), 64'd0);
    check("t4_no_gnt", 64'(rq_gnt), 64'd0);
    @(negedge clk);
    #3;
    check("t4_back_idle", 64'(arb_busy), 64'd0);

    // stray fetch_done while idle
    fetch_done = 1'b1;
    #1;
    check("t5_no_done_idle", 64'(rq_done), 64'd0);
    @(negedge clk);
    fetch_done = 1'b0;
    #3;
    check("t5_still_idle", 64'(arb_busy), 64'd0);
    check("t5_no_done_after", 64'(rq_done), 64'd0);

    // reset while BUSY, coinciding with fetch_done
    do_reset();
    rq_req = 2'b01;
    @(negedge clk);
    fetch_gnt = 1'b1;
    @(negedge clk);
    fetch_gnt  = 1'b0;
    rq_req     = '0;
    rst        = 1'b1;
    fetch_done = 1'b1;
    #3;
    check("t6_busy_before_rst", 64'(arb_busy), 64'd1);
    check("t6_no_done_in_rst", 64'(rq_done), 64'd0);
    @(negedge clk);
    rst        = 1'b0;
    fetch_done = 1'b0;
    #3;
    check("t6_idle_after_rst", 64'(arb_busy), 64'd0);
    check("t6_no_done_after", 64'(rq_done), 64'd0);
    check("t6_owner_cleared", 64'(arb_owner), 64'd0);

`ifdef FETCH_ARB_WATCHDOG_EN
    // fetch that never completes trips the watchdog, which stays set
    do_reset();
    rq_req = 2'b01;
    @(negedge clk);
    fetch_gnt = 1'b1;
    @(negedge clk);
    fetch_gnt = 1'b0;
    rq_req    = '0;
    repeat (65000) @(negedge clk);
    #3;
    check("wd_not_yet", 64'(wdog_err), 64'd0);
    repeat (600) @(negedge clk);
    #3;
    check("wd_tripped", 64'(wdog_err), 64'd1);
    @(negedge clk);
    fetch_done = 1'b1;
    @(negedge clk);
    fetch_done = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check("wd_sticky", 64'(wdog_err), 64'd1);
    check("wd_idle_after_done", 64'(arb_busy), 64'd0);
`endif

    // randomized traffic against the transaction model
    do_reset();
    pend    = '0;
    phase   = 0;
    m_own   = 0;
    m_ptr   = 0;
    hs_last = 1'b0;
    for (int i = 0; i < NR; i++) begin
      p_cmd[i]  = '0;
      p_tag[i]  = '0;
      p_addr[i] = '0;
    end
    mon_en = 1'b1;
    for (int c = 0; c < RAND_CYCLES + DRAIN_CYCLES; c++) begin
      bit drain;
      drain = (c >= RAND_CYCLES);
      @(negedge clk);
      // granted requester lowers its request after the handshake edge
      if (hs_last) begin
        pend[m_own] = 1'b0;
        hs_last     = 1'b0;
      end
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && !drain && $urandom_range(0, 3) == 0) begin
          pend[i]   = 1'b1;
          p_cmd[i]  = 2'($urandom_range(0, 1));
          p_tag[i]  = TW'($urandom);
          p_addr[i] = $urandom;
        end
        rq_req[i]  = pend[i];
        rq_cmd[i]  = p_cmd[i];
        rq_tag[i]  = p_tag[i];
        rq_addr[i] = p_addr[i];
      end
      fetch_gnt  = drain ? 1'b1 : ($urandom_range(0, 1) == 1);
      fetch_done = drain ? 1'b1 : ($urandom_range(0, 3) == 0);
      // what the coming edge does to the shared engine
      case (phase)
        0: if (pend != '0) begin
          bit          found;
          int unsigned k;
          found = 1'b0;
          k     = 0;
          for (int j = 0; j < NR; j++) begin
            int unsigned q;
            q = (m_ptr + j) % NR;
            if (!found && pend[q]) begin
              found = 1'b1;
              k     = q;
            end
          end
          exp_gnt_q.push_back('{idx: k, cmd: p_cmd[k], tag: p_tag[k], addr: p_addr[k]});
          m_own = k;
          phase = 1;
        end
        1: if (fetch_gnt) begin
          hs_last = 1'b1;
          phase   = 2;
        end
        default: if (fetch_done) begin
          exp_done_q.push_back(m_own);
          m_ptr = (m_own + 1) % NR;
          phase = 0;
        end
      endcase
    end
    @(negedge clk);
    clr_inputs();
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    check("sb_grants_drained", 64'(exp_gnt_q.size()), 64'd0);
    check("sb_dones_drained", 64'(exp_done_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
